// File: rtl/led_pwm_driver.sv
// LED PWM driver: OFF/ON/BLINK/BREATHE, commands applied on frame boundaries; BREATHE built only with LED_BREATHE_EN.
// led_out lags pwm_cnt by one clock; cmd_ready stays low while a command waits for frame_end.
module led_pwm_driver #(
  parameter int DIV_WIDTH    = 8,
  parameter int PWM_WIDTH    = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [PWM_WIDTH-1:0] cmd_level,
  output logic                 led_out,
  output logic                 frame_start
);

  localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {
    ST_RUN,
    ST_PENDING
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [PWM_WIDTH-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [1:0]             pend_mode_q, pend_mode_d;
  logic [PWM_WIDTH-1:0]   pend_level_q, pend_level_d;
  logic [1:0]             act_mode_q, act_mode_d;
  logic [PWM_WIDTH-1:0]   act_level_q, act_level_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                   blink_dark_q, blink_dark_d;
  logic                   frame_start_q, frame_start_d;
  logic                   led_q, led_d;
`ifdef LED_BREATHE_EN
  logic [PWM_WIDTH-1:0]   breathe_lvl_q, breathe_lvl_d;
  logic                   breathe_down_q, breathe_down_d;
`endif

  logic tick;
  logic frame_end;
  logic fc_wrap;
  logic pend_load;
  logic apply;

  assign tick      = &presc_q;
  assign frame_end = tick && (&pwm_cnt_q);
  assign fc_wrap   = frame_end && (frame_cnt_q == FC_LAST);

  // Control FSM: a command parks in the pending registers until frame_end.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    pend_load = 1'b0;
    apply     = 1'b0;
    case (state_q)
      ST_RUN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          pend_load = 1'b1;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_end) begin
          apply   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    presc_d       = presc_q + 1'b1;
    pwm_cnt_d     = pwm_cnt_q;
    pend_mode_d   = pend_mode_q;
    pend_level_d  = pend_level_q;
    act_mode_d    = act_mode_q;
    act_level_d   = act_level_q;
    frame_cnt_d   = frame_cnt_q;
    blink_dark_d  = blink_dark_q;
    frame_start_d = frame_end;

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    if (pend_load) begin
      pend_mode_d  = cmd_mode;
      pend_level_d = cmd_level;
    end

    // A fresh command restarts blink in the lit phase.
    if (apply) begin
      act_mode_d   = pend_mode_q;
      act_level_d  = pend_level_q;
      frame_cnt_d  = '0;
      blink_dark_d = 1'b0;
    end else if (frame_end) begin
      frame_cnt_d = fc_wrap ? '0 : frame_cnt_q + 1'b1;
      if (fc_wrap) begin
        blink_dark_d = ~blink_dark_q;
      end
    end
  end

`ifdef LED_BREATHE_EN
  // Triangle ramp 0..level..0; at each endpoint the step only flips direction.
  always_comb begin
    breathe_lvl_d  = breathe_lvl_q;
    breathe_down_d = breathe_down_q;
    if (apply) begin
      breathe_lvl_d  = '0;
      breathe_down_d = 1'b0;
    end else if (fc_wrap) begin
      if (!breathe_down_q) begin
        if (breathe_lvl_q == act_level_q) begin
          breathe_down_d = 1'b1;
        end else begin
          breathe_lvl_d = breathe_lvl_q + 1'b1;
        end
      end else begin
        if (breathe_lvl_q == '0) begin
          breathe_down_d = 1'b0;
        end else begin
          breathe_lvl_d = breathe_lvl_q - 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    led_d = 1'b0;
    case (act_mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = (pwm_cnt_q < act_level_q);
      MODE_BLINK:   led_d = !blink_dark_q && (pwm_cnt_q < act_level_q);
`ifdef LED_BREATHE_EN
      MODE_BREATHE: led_d = (pwm_cnt_q < breathe_lvl_q);
`else
      MODE_BREATHE: led_d = (pwm_cnt_q < act_level_q);
`endif
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      pend_mode_q   <= MODE_OFF;
      pend_level_q  <= '0;
      act_mode_q    <= MODE_OFF;
      act_level_q   <= '0;
      frame_cnt_q   <= '0;
      blink_dark_q  <= 1'b0;
      frame_start_q <= 1'b0;
      led_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pend_mode_q   <= pend_mode_d;
      pend_level_q  <= pend_level_d;
      act_mode_q    <= act_mode_d;
      act_level_q   <= act_level_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_dark_q  <= blink_dark_d;
      frame_start_q <= frame_start_d;
      led_q         <= led_d;
    end
  end

`ifdef LED_BREATHE_EN
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      breathe_lvl_q  <= '0;
      breathe_down_q <= 1'b0;
    end else begin
      breathe_lvl_q  <= breathe_lvl_d;
      breathe_down_q <= breathe_down_d;
    end
  end
`endif

  assign led_out     = led_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
Output-side counterpart to the board-test switch debouncer: drives one physical LED pin from a registered command interface instead of conditioning a physical input. Uses the same free-running prescaler-tick scheme as the input side. Provides OFF / ON / BLINK / BREATHE modes with PWM dimming. Command changes take effect only on PWM frame boundaries, so the pin never glitches.

Parameters:
DIV_WIDTH, 8, prescaler width; one tick every 2^DIV_WIDTH clocks
PWM_WIDTH, 4, PWM counter and level width; frame = 2^PWM_WIDTH ticks
BLINK_FRAMES, 16, frames per blink half-period and per breathe step (>=1)

Ports:
sys_clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high = no command pending; transfer on cmd_valid && cmd_ready
cmd_mode  input  2  0 OFF, 1 ON, 2 BLINK, 3 BREATHE
cmd_level  input  PWM_WIDTH  brightness; duty = level / 2^PWM_WIDTH
led_out  output  1  LED pin, registered
frame_start  output  1  one-cycle pulse on first clock of each PWM frame

Behaviour:
- Reset (sys_clock edge with reset=1): led_out=0, cmd_ready=1, frame_start=0; active mode OFF, level 0; prescaler, pwm_cnt, frame_cnt, blink phase, breathe level and direction all cleared. Reset mid-frame or with a command pending drops the pending command.
- Prescaler: DIV_WIDTH-bit counter, increments every clock, wraps. tick=1 when prescaler is all-ones.
- pwm_cnt increments on tick and wraps from 2^PWM_WIDTH-1 to 0. frame_end = tick && pwm_cnt all-ones. frame_start is registered one cycle after frame_end.
- State machine, states RUN and PENDING:
  - RUN: cmd_ready=1. On handshake, latch mode and level into pending registers; go to PENDING. cmd_ready drops on the next clock.
  - PENDING: cmd_ready=0 and inputs are ignored. On frame_end, copy pending into active, clear frame_cnt, blink phase, breathe level and breathe direction, and return to RUN. cmd_ready=1 from the next clock.
  - A handshake in the same cycle as frame_end is applied at the next frame_end, not the current one.
- Frame counter: frame_cnt counts frame_end events up to BLINK_FRAMES-1 and then wraps. Blink phase toggles on the wrap (starts at 1 = lit).
- Breathe level: steps by 1 on each wrap. Ramps up to the active level, then down to 0, then up again. Direction reverses at both endpoints; each endpoint is held for one step.
- led_out is registered, one clock after the pwm_cnt value it reflects:
  - OFF: 0.
  - ON: pwm_cnt < level.
  - BLINK: phase && (pwm_cnt < level).
  - BREATHE: pwm_cnt < breathe_level.
- Level 0 gives a constant 0. Full-scale duty is (2^PWM_WIDTH-1)/2^PWM_WIDTH, never 100%.
- Arithmetic: all counters are unsigned and wrap modulo their width. The compare is unsigned and PWM_WIDTH wide.

Optional Feature:
LED_BREATHE_EN
- Defined: BREATHE mode behaves as described, including the breathe level and direction registers.
- Undefined: breathe registers are not built. Mode 3 behaves exactly as ON. Every other behaviour is identical.

Test Plan:
- Reset while BLINK is active with a pending command -> next clock led_out=0, cmd_ready=1; no led_out high for 3 full frames.
- DIV_WIDTH=2, PWM_WIDTH=4, cmd ON level 4 -> after the applying frame, each 64-clock frame has led_out high exactly 16 clocks, contiguous from frame_start.
- Handshake mid-frame -> cmd_ready low the next clock; new duty first appears in the frame following frame_start; cmd_ready high again one clock after frame_end.
- Handshake coincident with frame_end -> the current frame keeps the old duty, and the new duty is applied one frame later.
- BLINK, level 15, BLINK_FRAMES=2 -> 2 frames with 60 of 64 clocks high, then 2 frames with led_out=0, repeating.
- BREATHE, level 3, BLINK_FRAMES=1, LED_BREATHE_EN defined -> per-frame high-clock counts 0,4,8,12,12,8,4,0,0,4,... (4 clocks per tick); macro undefined -> constant 12 per frame.
